// File: rtl/aes_pkg.sv
// Shared AES definitions: field constants, GF(2^8) helpers and the stage-A beat record.
package aes_pkg;

    localparam int         STATE_W  = 128;
    localparam logic [7:0] AES_POLY = 8'h1B;

    // One pipeline slot: the (optionally mixed) state travelling with its round key.
    typedef struct packed {
        logic [STATE_W-1:0] data;
        logic [STATE_W-1:0] key;
    } beat_t;

    // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by 3 = x + 1.
    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// MixColumns for one 32-bit column; row 0 sits in the least significant byte.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] column,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = column[7:0];
    assign a1 = column[15:8];
    assign a2 = column[23:16];
    assign a3 = column[31:24];

    // Circulant matrix {2,3,1,1} applied to the column.
    assign mixed[7:0]   = xtime(a0)   ^ gf_mul3(a1) ^ a2          ^ a3;
    assign mixed[15:8]  = a0          ^ xtime(a1)   ^ gf_mul3(a2) ^ a3;
    assign mixed[23:16] = a0          ^ a1          ^ xtime(a2)   ^ gf_mul3(a3);
    assign mixed[31:24] = gf_mul3(a0) ^ a1          ^ a2          ^ xtime(a3);

endmodule

// File: rtl/mix_add_stage.sv
// AES round tail: MixColumns (skipped on the final round) into stage A, AddRoundKey into
// stage B, with a valid/ready chain so a stalled consumer back-pressures without loss.
module mix_add_stage
    import aes_pkg::*;
#(
    parameter int DATA_W  = STATE_W,  // state width; the byte layout assumes 128
    parameter bit REG_OUT = 1'b1      // 0 drops stage B and drives the output from stage A
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [DATA_W-1:0] inputData,
    input  logic [DATA_W-1:0] roundKey,
    input  logic              finalRound,
    input  logic              validIn,
    output logic              readyOut,
    output logic [DATA_W-1:0] outputData,
    output logic              validOut,
    input  logic              readyIn
);

    logic [DATA_W-1:0] mixed;
    beat_t             stage_a;
    beat_t             stage_a_next;
    logic              valid_a;
    logic              ready_a;
    logic              ready_b;

    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_single_column u_col (
            .column (inputData[32*c +: 32]),
            .mixed  (mixed[32*c +: 32])
        );
    end

    // Choose mixed or bypassed state for this beat and pair it with its key.
    always_comb begin
        // NOTE: assign a default to every field first so no path through this block can infer a latch.
        stage_a_next      = '0;
        stage_a_next.data = finalRound ? inputData : mixed;
        stage_a_next.key  = roundKey;
    end

    // A slot can take a beat when empty or when its current beat leaves this cycle.
    assign ready_a  = !valid_a || ready_b;
    assign readyOut = ready_a;

    // Stage A register: refill or empty whenever the slot is free, otherwise hold.
    always_ff @(posedge clock or negedge resetN) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetN) begin
            // NOTE: the data registers are reset as well, so a flushed pipeline shows all-zero state, not stale keys.
            valid_a <= 1'b0;
            stage_a <= '0;
        end else if (ready_a) begin
            valid_a <= validIn;
            if (validIn) begin
                stage_a <= stage_a_next;
            end
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic              valid_b;
        logic [DATA_W-1:0] data_b;

        assign ready_b = !valid_b || readyIn;

        // Stage B register: AddRoundKey on transfer from A; holds while the consumer stalls.
        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                valid_b <= 1'b0;
                data_b  <= '0;
            end else if (ready_b) begin
                valid_b <= valid_a;
                if (valid_a) begin
                    data_b <= stage_a.data ^ stage_a.key;
                end
            end
        end

        assign outputData = data_b;
        assign validOut   = valid_b;
    end else begin : g_comb_out
        assign ready_b    = readyIn;
        assign outputData = stage_a.data ^ stage_a.key;
        assign validOut   = valid_a;
    end

endmodule

// File: tb/tb_mix_add_stage.sv
// Bench for mix_add_stage: directed vectors, back-pressure, reset flush and a randomized
// handshake run, all scored against a matrix-form GF(2^8) model of the round.
module tb_mix_add_stage;

    logic         clock  = 1'b0;
    logic         resetN = 1'b1;
    logic [127:0] inputData = '0;
    logic [127:0] roundKey  = '0;
    logic         finalRound = 1'b0;
    logic         validIn = 1'b0;
    logic         readyOut;
    logic [127:0] outputData;
    logic         validOut;
    logic         readyIn = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] TV_IN    = 128'hc6c6c6c6_01010101_5c220af2_455313db;
    localparam logic [127:0] TV_MIX   = 128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e;
    localparam logic [127:0] TV_FINAL = 128'h39393939_fefefefe_a3ddf50d_baacec24;
    localparam logic [127:0] ONES     = {128{1'b1}};

    mix_add_stage dut (
        .clock      (clock),
        .resetN     (resetN),
        .inputData  (inputData),
        .roundKey   (roundKey),
        .finalRound (finalRound),
        .validIn    (validIn),
        .readyOut   (readyOut),
        .outputData (outputData),
        .validOut   (validOut),
        .readyIn    (readyIn)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        int k = b;
        while (k != 0) begin
            if (k[0]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
            k = k >> 1;
        end
        return p;
    endfunction

    // Round result: circulant matrix (2,3,1,1) per column unless final, then key XOR.
    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [127:0] r = s;
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    logic [7:0] acc = 8'h00;
                    for (int kk = 0; kk < 4; kk++) begin
                        int d = (kk - row + 4) % 4;
                        int coef = (d == 0) ? 2 : ((d == 1) ? 3 : 1);
                        acc ^= gmul(s[32*c + 8*kk +: 8], coef);
                    end
                    r[32*c + 8*row +: 8] = acc;
                end
            end
        end
        return r ^ k;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: expected results queued at acceptance, compared at consumption.
    logic [127:0] q[$];
    int           pops = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_out = '0;

    always @(negedge clock) begin
        if (!resetN) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            check("ready_out", 128'(readyOut), 128'((q.size() < 2) || readyIn));
            if (prev_stall) begin
                check("hold_valid", 128'(validOut), 128'(1));
                check("hold_data", outputData, prev_out);
            end
            if (validOut && readyIn) begin
                if (q.size() == 0) begin
                    check("spurious_out", 128'(validOut), 128'(0));
                end else begin
                    check("out_data", outputData, q.pop_front());
                    pops++;
                end
            end
            if (validIn && readyOut) q.push_back(model(inputData, roundKey, finalRound));
            prev_stall = validOut && !readyIn;
            prev_out   = outputData;
        end
    end

    // Present one beat and return once it has been taken (bounded wait).
    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic f, output int waits);
        waits      = 0;
        inputData  = d;
        roundKey   = k;
        finalRound = f;
        validIn    = 1'b1;
        forever begin
            @(negedge clock);
            if (readyOut) break;
            waits++;
            if (waits > 20) begin
                check("send_timeout", 128'(waits), 128'(0));
                break;
            end
        end
        @(posedge clock);
        #1;
        validIn = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   tot_wait;
        int   p0;
        logic fire;
        logic [127:0] b [3];

        // Reset state
        #2 resetN = 1'b0;
        #1;
        check("rst_valid", 128'(validOut), 128'(0));
        check("rst_data", outputData, '0);
        #19 resetN = 1'b1;
        @(posedge clock);
        #1;
        check("rst_ready", 128'(readyOut), 128'(1));

        // MixColumns vector, exact latency
        send(TV_IN, '0, 1'b0, w);
        check("mc_early", 128'(validOut), 128'(0));
        @(posedge clock);
        #1;
        check("mc_valid", 128'(validOut), 128'(1));
        check("mc_data", outputData, TV_MIX);

        // Final-round bypass
        send(TV_IN, ONES, 1'b1, w);
        @(posedge clock);
        #1;
        check("fin_valid", 128'(validOut), 128'(1));
        check("fin_data", outputData, TV_FINAL);
        @(posedge clock);
        #1;
        check("fin_drained", 128'(validOut), 128'(0));

        // Back-pressure: two beats fill the pipe, the third must wait
        for (int i = 0; i < 3; i++) b[i] = rand128();
        readyIn = 1'b0;
        send(b[0], b[1], 1'b0, w);
        send(b[1], b[2], 1'b1, w);
        inputData  = b[2];
        roundKey   = b[0];
        finalRound = 1'b0;
        validIn    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_ready_low", 128'(readyOut), 128'(0));
            check("bp_head", outputData, model(b[0], b[1], 1'b0));
            @(posedge clock);
            #1;
        end
        p0 = pops;
        readyIn = 1'b1;
        send(b[2], b[0], 1'b0, w);
        repeat (4) @(posedge clock);
        #1;
        check("bp_count", 128'(pops - p0), 128'(3));
        check("bp_empty", 128'(q.size()), 128'(0));

        // Back-to-back streaming with alternating finalRound
        p0 = pops;
        tot_wait = 0;
        for (int i = 0; i < 8; i++) begin
            send(rand128(), rand128(), 1'(i % 2), w);
            tot_wait += w;
        end
        repeat (3) @(posedge clock);
        #1;
        check("stream_waits", 128'(tot_wait), 128'(0));
        check("stream_count", 128'(pops - p0), 128'(8));

        // Reset mid-operation with two beats in flight
        readyIn = 1'b0;
        send(rand128(), rand128(), 1'b0, w);
        send(rand128(), rand128(), 1'b1, w);
        #2 resetN = 1'b0;
        #1;
        check("mid_rst_valid", 128'(validOut), 128'(0));
        check("mid_rst_data", outputData, '0);
        repeat (2) @(posedge clock);
        #3;
        resetN  = 1'b1;
        readyIn = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_ready", 128'(readyOut), 128'(1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("no_stale", 128'(validOut), 128'(0));
        end
        @(posedge clock);
        #1;

        // Randomized handshake; a presented beat is held until taken
        p0 = pops;
        validIn = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clock);
            fire = validIn && readyOut;
            @(posedge clock);
            #1;
            if (!validIn || fire) begin
                validIn    = ($urandom_range(0, 3) != 0);
                inputData  = rand128();
                roundKey   = rand128();
                finalRound = 1'($urandom_range(0, 1));
            end
            readyIn = ($urandom_range(0, 2) != 0);
        end
        validIn = 1'b0;
        readyIn = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("rand_drain", 128'(q.size()), 128'(0));
        check("rand_progress", 128'(pops - p0 > 200), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mix_add_stage.md
Name: mix_add_stage

Overview:
- Pipelined AES round stage directly downstream of shift_row.
- Takes the ShiftRows state and applies MixColumns (bypassed for the final round), then AddRoundKey.
- Produces the round output for the next round's sub_bytes.
- Two register stages with valid/ready flow control, so a stalled consumer back-pressures cleanly without dropping or duplicating states.

Parameters:
- DATA_W, 128, state width; fixed at 128, must not be overridden.
- REG_OUT, 1, when 1 stage B output is registered; when 0 outputData is combinational from stage A (latency 1). Default build uses 1.

Ports:
clock  input  1  system clock, rising edge
resetN  input  1  asynchronous active-low reset
inputData  input  128  state from shift_row
roundKey  input  128  round key, sampled with inputData
finalRound  input  1  1 = skip MixColumns, sampled with inputData
validIn  input  1  inputData/roundKey/finalRound valid
readyOut  output  1  stage can accept a beat this cycle
outputData  output  128  round result
validOut  output  1  outputData valid
readyIn  input  1  downstream accepts outputData

Behaviour:
- One clock; reset is asynchronous and active-low.
- State byte layout (same as shift_row):
  - column c occupies bits [32c+31:32c];
  - row r within a column occupies bits [32c+8r+7:32c+8r] (row 0 at the LSB).
- MixColumns per column, GF(2^8) with polynomial 0x11B:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0).
- Stage A register, loaded on a beat (validIn & readyOut):
  - dataA = finalRound ? inputData : MixColumns(inputData);
  - keyA = roundKey; validA = 1.
- Stage B register, REG_OUT=1:
  - loaded when validA & readyA;
  - outputData = dataA ^ keyA; validB = 1.
- Ready chain:
  - readyB = !validB | readyIn
  - readyA = !validA | readyB
  - readyOut = readyA (combinational path from readyIn, accepted).
- Valid clearing: a valid register clears on a cycle where it is consumed and not refilled.
- Latency: 2 cycles from accepted beat to validOut when not stalled. Throughput: 1 beat/cycle.
- Stall:
  - while validOut & !readyIn, outputData and validOut hold stable;
  - stage A holds if full;
  - the stage accepts at most 2 beats in flight, then readyOut=0.
- Simultaneous consume and accept in one cycle: the register takes the new data; validity stays 1.
- Reset (async assert, mid-operation included):
  - validA, validB, validOut = 0;
  - dataA, keyA, outputData = 0;
  - readyOut = 1 on the first cycle after deassertion;
  - in-flight beats are discarded.
- finalRound travels with its beat only; it has no effect on other beats.
- REG_OUT=0: stage B removed; outputData = dataA ^ keyA; validOut = validA; readyA = !validA | readyIn.

Decomposition:
- Package aes_pkg: xtime and gf_mul3 functions, AES_POLY = 8'h1B, STATE_W = 128.
- Sub-module mix_single_column: combinational 32-bit in/out, instantiated 4×.
- AddRoundKey XOR and pipeline registers live in mix_add_stage.

Test Plan:
- MixColumns vector, no stall:
  - inputData = c6c6c6c6_01010101_5c220af2_455313db, roundKey = 0, finalRound = 0, readyIn = 1.
  - Required: validOut high exactly 2 cycles later; outputData = c6c6c6c6_01010101_9d58dc9f_bca14d8e.
- Final-round bypass:
  - same inputData, roundKey = ffffffff_ffffffff_ffffffff_ffffffff, finalRound = 1.
  - Required: outputData = 39393939_fefefefe_a3ddf50d_baacec24.
- Back-pressure:
  - hold readyIn = 0 and stream 3 beats.
  - Required: readyOut drops after 2 accepted; outputData stable.
  - On release, beats emerge in order with none lost or duplicated.
- Back-to-back streaming:
  - 8 consecutive beats with alternating finalRound, readyIn = 1.
  - Required: one result per cycle; each matches the golden model.
- Reset mid-operation:
  - assert resetN = 0 asynchronously between clock edges with 2 beats in flight.
  - Required: validOut = 0 and outputData = 0 immediately; readyOut = 1 after release; no stale beat appears.
- Random handshake:
  - randomized validIn/readyIn for 1000 cycles against a scoreboard.
  - Required: order and values match; outputData never changes while validOut & !readyIn.
